// File: rtl/block_sram_pkg.sv
// Shared types and helpers for the AES block store: FSM state encoding and beat-count arithmetic.
package block_sram_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} bsc_state_t;

  function automatic int beats(input int block_w, input int word_w);
    return block_w / word_w;
  endfunction

  function automatic bit ratio_ok(input int block_w, input int word_w);
    return (word_w > 0) && (word_w % 8 == 0) && (block_w >= word_w) && (block_w % word_w == 0);
  endfunction

endpackage

// File: rtl/sram_word_array.sv
// Single-port word array with a one-cycle registered read; a write also updates the read register.
module sram_word_array #(
  parameter int WORD_W      = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [WORD_W-1:0]              wdata,
  output logic [WORD_W-1:0]              rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata_q   <= wdata;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/block_sram_ctrl.sv
// Moves BLOCK_W-bit blocks into and out of a WORD_W-bit word array, one word per beat,
// with valid/ready handshakes on the request and response sides.
module block_sram_ctrl
  import block_sram_pkg::*;
#(
  parameter int BLOCK_W     = 128,
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [BLOCK_W-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BLOCK_W-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               busy
);

  localparam int N  = beats(BLOCK_W, WORD_W);
  localparam int WB = WORD_W / 8;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(N + 1);
  localparam logic [31:0] WB_U    = 32'(WB);
  localparam logic [31:0] BB_U    = 32'(BLOCK_W / 8);
  localparam logic [31:0] LIMIT_U = 32'(DEPTH_WORDS - N);

  if (!ratio_ok(BLOCK_W, WORD_W)) begin : g_bad_ratio
    $error("block_sram_ctrl: BLOCK_W must be a multiple of WORD_W, WORD_W a multiple of 8");
  end
  if (DEPTH_WORDS < N || ADDR_W > 32) begin : g_bad_geometry
    $error("block_sram_ctrl: DEPTH_WORDS must hold one block and ADDR_W must be <= 32");
  end

  bsc_state_t         state_q, state_d;
  logic [CW-1:0]      beat_q, beat_d;
  logic [AW-1:0]      widx_q, widx_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;
  logic [BLOCK_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               req_ready_q, req_ready_d;
  logic               busy_q, busy_d;

  logic [31:0]        addr_ext, widx_ext;
  logic               req_bad;
  logic               mem_we, mem_re;
  logic [AW-1:0]      mem_addr;
  logic [WORD_W-1:0]  mem_wdata, mem_rdata;

  always_comb begin
    addr_ext = 32'(req_addr);
    widx_ext = addr_ext / WB_U;
    req_bad  = ((addr_ext % BB_U) != 32'd0) || (widx_ext > LIMIT_U);
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    widx_d      = widx_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_wdata   = '0;
    for (int s = 0; s < N; s++) begin
      if (beat_q == CW'(s)) mem_wdata = wdata_q[s*WORD_W +: WORD_W];
    end

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          widx_d      = AW'(widx_ext);
          wdata_d     = req_wdata;
          beat_d      = '0;
          rsp_rdata_d = '0;
          if (req_bad) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            state_d = req_write ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        if (beat_q == CW'(N - 1)) state_d = RESP;
        else                      beat_d  = beat_q + CW'(1);
      end
      // Issue runs one beat ahead of capture: beat k issues word k and captures word k-1.
      READ: begin
        mem_re = (beat_q != CW'(N));
        for (int s = 0; s < N; s++) begin
          if (beat_q == CW'(s + 1)) rsp_rdata_d[s*WORD_W +: WORD_W] = mem_rdata;
        end
        if (beat_q == CW'(N)) state_d = RESP;
        else                  beat_d  = beat_q + CW'(1);
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    rsp_valid_d = (state_d == RESP);
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    widx_q  <= widx_d;
    wdata_q <= wdata_d;
  end

  // A reset landing on a WRITE beat must not commit that beat.
  assign mem_addr = widx_q + AW'(beat_q);

  sram_word_array #(
    .WORD_W      (WORD_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we && !rst),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_block_sram_ctrl.sv
// Drives three block_sram_ctrl instances (WORD_W 32/16/128) in lockstep against a byte-level reference memory.
module tb_block_sram_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [15:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         rsp_ready = 1'b1;

  logic         req_ready_o [3];
  logic         rsp_valid_o [3];
  logic [127:0] rsp_rdata_o [3];
  logic         rsp_err_o   [3];
  logic         busy_o      [3];

  int checks = 0;
  int fails  = 0;

  logic [7:0] ref_mem [3][16384];
  bit         written [64];

  always #5 clk = ~clk;

  block_sram_ctrl #(.BLOCK_W(128), .WORD_W(32), .ADDR_W(16), .DEPTH_WORDS(1024)) u_dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_o[0]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_o[0]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_o[0]), .rsp_err(rsp_err_o[0]), .busy(busy_o[0]));

  block_sram_ctrl #(.BLOCK_W(128), .WORD_W(16), .ADDR_W(16), .DEPTH_WORDS(1024)) u_dut16 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_o[1]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_o[1]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_o[1]), .rsp_err(rsp_err_o[1]), .busy(busy_o[1]));

  block_sram_ctrl #(.BLOCK_W(128), .WORD_W(128), .ADDR_W(16), .DEPTH_WORDS(1024)) u_dut128 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_o[2]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_o[2]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_o[2]), .rsp_err(rsp_err_o[2]), .busy(busy_o[2]));

  function automatic int wb_of(input int d);
    case (d)
      0:       return 4;
      1:       return 2;
      default: return 16;
    endcase
  endfunction

  function automatic int ww_of(input int d);
    return 8 * wb_of(d);
  endfunction

  function automatic bit model_err(input int d, input int addr);
    return (addr % 16 != 0) || (addr / wb_of(d) + 16 / wb_of(d) > 1024);
  endfunction

  function automatic logic [127:0] model_read(input int d, input int addr);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = ref_mem[d][addr + i];
    return v;
  endfunction

  task automatic model_write(input int d, input int addr, input logic [127:0] data, input int nbytes);
    for (int i = 0; i < nbytes; i++) ref_mem[d][addr + i] = data[8*i +: 8];
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_req();
    req_write = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Watches all three responses after an accept edge; entered just after that edge.
  task automatic run_rsp(input string tag, input bit wr, input logic [15:0] addr, input logic [127:0] wd);
    int           lat_exp [3];
    bit           err_exp [3];
    logic [127:0] rd_exp  [3];
    bit           done    [3];
    int           a;
    a = int'(addr);
    for (int d = 0; d < 3; d++) begin
      err_exp[d] = model_err(d, a);
      lat_exp[d] = err_exp[d] ? 1 : (wr ? 16 / wb_of(d) + 1 : 16 / wb_of(d) + 2);
      rd_exp[d]  = (wr || err_exp[d]) ? 128'd0 : model_read(d, a);
      done[d]    = 1'b0;
    end
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!done[d]) begin
          if (rsp_valid_o[d] === 1'b1) begin
            done[d] = 1'b1;
            chk($sformatf("%s_lat_w%0d", tag, ww_of(d)), 128'(j + 1), 128'(lat_exp[d]));
            chk($sformatf("%s_err_w%0d", tag, ww_of(d)), 128'(rsp_err_o[d]), 128'(err_exp[d]));
            chk($sformatf("%s_data_w%0d", tag, ww_of(d)), rsp_rdata_o[d], rd_exp[d]);
          end else begin
            chk($sformatf("%s_busy_w%0d", tag, ww_of(d)), 128'(busy_o[d]), 128'd1);
          end
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_responded_w%0d", tag, ww_of(d)), 128'(done[d]), 128'd1);
      if (wr && !err_exp[d]) model_write(d, a, wd, 16);
    end
    if (wr && !model_err(0, a) && a < 1024) written[a / 16] = 1'b1;
  endtask

  // Entered at a negedge with all instances idle.
  task automatic do_req(input string tag, input bit wr, input logic [15:0] addr, input logic [127:0] wd);
    for (int d = 0; d < 3; d++)
      chk($sformatf("%s_rdy_w%0d", tag, ww_of(d)), 128'(req_ready_o[d]), 128'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble_req();
    run_rsp(tag, wr, addr, wd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key;
    logic [127:0] a_data, b_data, rdat;
    logic [15:0]  addr;
    int           blk, sel;
    bit           wr;
    key = 128'h09CF4F3C_ABF71588_28AED2A6_2B7E1516;
    for (int i = 0; i < 64; i++) written[i] = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ready_w%0d", ww_of(d)), 128'(req_ready_o[d]), 128'd1);
      chk($sformatf("rst_valid_w%0d", ww_of(d)), 128'(rsp_valid_o[d]), 128'd0);
      chk($sformatf("rst_err_w%0d", ww_of(d)), 128'(rsp_err_o[d]), 128'd0);
      chk($sformatf("rst_rdata_w%0d", ww_of(d)), rsp_rdata_o[d], 128'd0);
      chk($sformatf("rst_busy_w%0d", ww_of(d)), 128'(busy_o[d]), 128'd0);
    end

    // Known-answer write and read-back
    do_req("t1_wr", 1'b1, 16'h0000, key);
    chk("t1_word0", 128'(u_dut32.u_array.mem[0]), 128'h2B7E1516);
    chk("t1_word3", 128'(u_dut32.u_array.mem[3]), 128'h09CF4F3C);
    do_req("t2_rd", 1'b0, 16'h0000, 128'd0);

    // Misaligned read, then a write past the end of the 32- and 16-bit arrays
    do_req("t3_misal", 1'b0, 16'h0004, 128'd0);
    do_req("t3_range", 1'b1, 16'h1000, {4{32'hDEADBEEF}});
    chk("t3_word0_kept", 128'(u_dut32.u_array.mem[0]), 128'h2B7E1516);

    // Back-pressure: response held while a second write waits
    a_data = {$urandom, $urandom, $urandom, $urandom};
    b_data = {$urandom, $urandom, $urandom, $urandom};
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0100;
    req_wdata = a_data;
    @(posedge clk);
    #1;
    req_addr  = 16'h0200;
    req_wdata = b_data;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j >= 10) begin
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("t4_hold_valid_w%0d", ww_of(d)), 128'(rsp_valid_o[d]), 128'd1);
          chk($sformatf("t4_hold_err_w%0d", ww_of(d)), 128'(rsp_err_o[d]), 128'd0);
          chk($sformatf("t4_hold_rdata_w%0d", ww_of(d)), rsp_rdata_o[d], 128'd0);
          chk($sformatf("t4_hold_ready_w%0d", ww_of(d)), 128'(req_ready_o[d]), 128'd0);
        end
      end
    end
    for (int d = 0; d < 3; d++) model_write(d, 16'h0100, a_data, 16);
    written[16'h0100 / 16] = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("t4_release_valid_w%0d", ww_of(d)), 128'(rsp_valid_o[d]), 128'd0);
      chk($sformatf("t4_release_ready_w%0d", ww_of(d)), 128'(req_ready_o[d]), 128'd1);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble_req();
    run_rsp("t4_second", 1'b1, 16'h0200, b_data);
    do_req("t4_rd_a", 1'b0, 16'h0100, 128'd0);
    do_req("t4_rd_b", 1'b0, 16'h0200, 128'd0);

    // Reset on the second WRITE beat
    do_req("t5_zero", 1'b1, 16'h0010, 128'd0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0010;
    req_wdata = {128{1'b1}};
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble_req();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("t5_valid_w%0d", ww_of(d)), 128'(rsp_valid_o[d]), 128'd0);
      chk($sformatf("t5_ready_w%0d", ww_of(d)), 128'(req_ready_o[d]), 128'd1);
      chk($sformatf("t5_busy_w%0d", ww_of(d)), 128'(busy_o[d]), 128'd0);
      model_write(d, 16'h0010, {128{1'b1}}, wb_of(d));
    end
    rst = 1'b0;
    @(negedge clk);
    rdat = model_read(0, 16'h0010);
    chk("t5_model_w32", rdat, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
    do_req("t5_rd", 1'b0, 16'h0010, 128'd0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      sel = int'($urandom_range(0, 9));
      blk = int'($urandom_range(0, 63));
      if (sel == 0) begin
        addr = 16'(blk * 16 + int'($urandom_range(1, 15)));
        wr   = 1'($urandom);
      end else if (sel == 1) begin
        addr = 16'(16'h4000 + 16 * int'($urandom_range(0, 1023)));
        wr   = 1'($urandom);
      end else begin
        addr = 16'(blk * 16);
        wr   = !written[blk] || ($urandom_range(0, 1) == 1);
      end
      do_req($sformatf("rnd%0d", n), wr, addr, {$urandom, $urandom, $urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule
